// File: rtl/decode_pkg.sv
// Shared types and sizing for the decode-stage branch ID allocator.
// Branch IDs are 4-bit pointers: bits [2:0] index the 8-entry branch record table,
// bit 3 is the wrap bit that separates a full table from an empty one.
package decode_pkg;

    localparam int BID_W      = 4;
    localparam int BRT_DEPTH  = 8;
    localparam int ROB_ADDR_W = 5;
    localparam int TGT_W      = 32;

    // Allocator mode: RUN accepts requests, HOLD blocks allocation after an override.
    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } bta_state_e;

    typedef logic [BID_W-1:0] bid_t;

    // Prediction record handed to the branch record table.
    typedef struct packed {
        bid_t                  bid;
        logic                  taken;
        logic                  hit;
        logic [TGT_W-1:0]      target;
        logic [ROB_ADDR_W-1:0] rob;
    } bp_rec_t;

    // Pointer increment; the 4-bit width makes the 15 -> 0 wrap implicit.
    function automatic bid_t bid_next(input bid_t b);
        return b + bid_t'(1);
    endfunction

endpackage

// File: rtl/decode_bta.sv
// Branch ID allocator: hands out in-order branch IDs, tracks commits, recovers from overrides.
// Latency: prediction record registered, valid one cycle after accept.
// Backpressure: o_br_ready low when table full, in HOLD, or on an override cycle.
// Optional protocol checking is enabled with macro DECODE_BTA_ERRCHK_EN.
import decode_pkg::*;

module decode_bta #(
    parameter int RECOVER_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  i_br_valid,
    input  logic                  i_br_taken,
    input  logic                  i_br_hit,
    input  logic [TGT_W-1:0]      i_br_target,
    input  logic [ROB_ADDR_W-1:0] i_br_rob,
    output logic                  o_br_ready,
    output logic                  o_bp_valid,
    output logic [BID_W-1:0]      o_bp_bid,
    output logic                  o_bp_taken,
    output logic                  o_bp_hit,
    output logic [TGT_W-1:0]      o_bp_target,
    output logic [ROB_ADDR_W-1:0] o_bp_rob,
    input  logic                  i_bc_valid,
    input  logic [BID_W-1:0]      i_bc_bid,
    input  logic                  i_bco_valid,
    input  logic [BID_W-1:0]      i_bco_bid,
    output logic                  o_empty,
    output logic                  o_err
);

    bid_t       head_q, head_d;
    bid_t       tail_q, tail_d;
    bta_state_e state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic       bp_vld_q, bp_vld_d;
    bp_rec_t    bp_q, bp_d;

    bid_t count;
    logic full;
    logic empty;
    logic accept;

    // Occupancy from registered pointers only; a commit this cycle frees a slot next cycle.
    assign count  = tail_q - head_q;
    assign full   = (count == bid_t'(BRT_DEPTH));
    assign empty  = (count == '0);

    assign o_br_ready = (state_q == ST_RUN) & ~full & ~i_bco_valid;
    assign accept     = i_br_valid & o_br_ready;
    assign o_empty    = empty;

    // Next head/tail: allocate at tail, commit at head, override collapses both past the mispredict.
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        if (accept) begin
            tail_d = bid_next(tail_q);
        end
        if (i_bc_valid) begin
            head_d = bid_next(head_q);
        end
        if (i_bco_valid) begin
            head_d = bid_next(i_bco_bid);
            tail_d = bid_next(i_bco_bid);
        end
    end

    // Recovery FSM: an override parks allocation for RECOVER_CYCLES cycles; a repeat override restarts the wait.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_RUN: begin
                if (i_bco_valid) begin
                    state_d = ST_HOLD;
                    cnt_d   = 3'(RECOVER_CYCLES);
                end
            end
            ST_HOLD: begin
                if (i_bco_valid) begin
                    cnt_d = 3'(RECOVER_CYCLES);
                end else if (cnt_q <= 3'd1) begin
                    state_d = ST_RUN;
                    cnt_d   = 3'd0;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = 3'd0;
            end
        endcase
    end

    // Prediction record capture: payload loads only on accept, valid pulses for one cycle.
    always_comb begin
        bp_vld_d = accept;
        bp_d     = bp_q;
        if (accept) begin
            bp_d.bid    = tail_q;
            bp_d.taken  = i_br_taken;
            bp_d.hit    = i_br_hit;
            bp_d.target = i_br_target;
            bp_d.rob    = i_br_rob;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            head_q   <= '0;
            tail_q   <= '0;
            state_q  <= ST_RUN;
            cnt_q    <= 3'd0;
            bp_vld_q <= 1'b0;
            bp_q     <= '0;
        end else begin
            head_q   <= head_d;
            tail_q   <= tail_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bp_vld_q <= bp_vld_d;
            bp_q     <= bp_d;
        end
    end

    assign o_bp_valid  = bp_vld_q;
    assign o_bp_bid    = bp_q.bid;
    assign o_bp_taken  = bp_q.taken;
    assign o_bp_hit    = bp_q.hit;
    assign o_bp_target = bp_q.target;
    assign o_bp_rob    = bp_q.rob;

`ifdef DECODE_BTA_ERRCHK_EN
    logic err_q, err_d;

    // Sticky error: a commit with nothing in flight or out of order marks the protocol broken.
    always_comb begin
        err_d = err_q;
        if (i_bc_valid && (empty || (i_bc_bid != head_q))) begin
            err_d = 1'b1;
        end
    end

    // Error flag register, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign o_err = err_q;
`else
    logic unused_bc_bid;
    assign unused_bc_bid = ^i_bc_bid;
    assign o_err         = 1'b0;
`endif

endmodule

// File: tb/tb_decode_bta.sv
// Self-checking bench for decode_bta: directed scenarios plus a prediction-record scoreboard.
// Inputs change 1 time unit after posedge; outputs are sampled around the negedge.
// Scenarios cover reset, single request, full table, wrap, override recovery, back-to-back, errors.
`timescale 1ns/1ps
import decode_pkg::*;

module tb_decode_bta;

    logic                  clk;
    logic                  resetn;
    logic                  i_br_valid, i_br_taken, i_br_hit;
    logic [TGT_W-1:0]      i_br_target;
    logic [ROB_ADDR_W-1:0] i_br_rob;
    logic                  o_br_ready;
    logic                  o_bp_valid;
    logic [BID_W-1:0]      o_bp_bid;
    logic                  o_bp_taken, o_bp_hit;
    logic [TGT_W-1:0]      o_bp_target;
    logic [ROB_ADDR_W-1:0] o_bp_rob;
    logic                  i_bc_valid, i_bco_valid;
    logic [BID_W-1:0]      i_bc_bid, i_bco_bid;
    logic                  o_empty, o_err;

    int checks   = 0;
    int failures = 0;

`ifdef DECODE_BTA_ERRCHK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    decode_bta #(.RECOVER_CYCLES(2)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .i_br_valid  (i_br_valid),
        .i_br_taken  (i_br_taken),
        .i_br_hit    (i_br_hit),
        .i_br_target (i_br_target),
        .i_br_rob    (i_br_rob),
        .o_br_ready  (o_br_ready),
        .o_bp_valid  (o_bp_valid),
        .o_bp_bid    (o_bp_bid),
        .o_bp_taken  (o_bp_taken),
        .o_bp_hit    (o_bp_hit),
        .o_bp_target (o_bp_target),
        .o_bp_rob    (o_bp_rob),
        .i_bc_valid  (i_bc_valid),
        .i_bc_bid    (i_bc_bid),
        .i_bco_valid (i_bco_valid),
        .i_bco_bid   (i_bco_bid),
        .o_empty     (o_empty),
        .o_err       (o_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: expected prediction records queued at accept, checked when o_bp_valid fires.
    bp_rec_t sb_q[$];
    bid_t    m_tail = '0;

    always @(negedge clk) begin
        bp_rec_t exp_r;
        bp_rec_t got_r;
        if (o_bp_valid) begin
            checks++;
            got_r = '{bid: o_bp_bid, taken: o_bp_taken, hit: o_bp_hit, target: o_bp_target, rob: o_bp_rob};
            if (sb_q.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected got=%h exp=none", got_r);
            end else begin
                exp_r = sb_q.pop_front();
                if (got_r !== exp_r) begin
                    failures++;
                    $display("FAIL sb_record got=%h exp=%h", got_r, exp_r);
                end
            end
        end
        if (!resetn) begin
            sb_q.delete();
            m_tail = '0;
        end else begin
            if (i_br_valid && o_br_ready) begin
                exp_r = '{bid: m_tail, taken: i_br_taken, hit: i_br_hit, target: i_br_target, rob: i_br_rob};
                sb_q.push_back(exp_r);
                m_tail = m_tail + bid_t'(1);
            end
            if (i_bco_valid) begin
                m_tail = i_bco_bid + bid_t'(1);
            end
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        i_br_valid  = 1'b0;
        i_br_taken  = 1'b0;
        i_br_hit    = 1'b0;
        i_br_target = '0;
        i_br_rob    = '0;
        i_bc_valid  = 1'b0;
        i_bc_bid    = '0;
        i_bco_valid = 1'b0;
        i_bco_bid   = '0;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        idle();
        nxt();
        nxt();
        resetn = 1'b1;
    endtask

    task automatic req(input logic [TGT_W-1:0] tgt, input logic [ROB_ADDR_W-1:0] rob);
        i_br_valid  = 1'b1;
        i_br_taken  = tgt[2];
        i_br_hit    = tgt[3];
        i_br_target = tgt;
        i_br_rob    = rob;
    endtask

    task automatic test_reset();
        do_reset();
        mid();
        checks++; if (o_empty !== 1'b1)     begin failures++; $display("FAIL rst_empty got=%b exp=1", o_empty); end
        checks++; if (o_br_ready !== 1'b1)  begin failures++; $display("FAIL rst_ready got=%b exp=1", o_br_ready); end
        checks++; if (o_bp_valid !== 1'b0)  begin failures++; $display("FAIL rst_bp_valid got=%b exp=0", o_bp_valid); end
        checks++; if (o_bp_bid !== 4'h0)    begin failures++; $display("FAIL rst_bp_bid got=%h exp=0", o_bp_bid); end
        checks++; if (o_bp_target !== 32'h0) begin failures++; $display("FAIL rst_bp_target got=%h exp=0", o_bp_target); end
        checks++; if (o_err !== 1'b0)       begin failures++; $display("FAIL rst_err got=%b exp=0", o_err); end
    endtask

    task automatic test_single();
        do_reset();
        req(32'h0000_1000, 5'h0A);
        mid();
        checks++; if (o_br_ready !== 1'b1) begin failures++; $display("FAIL single_ready got=%b exp=1", o_br_ready); end
        nxt();
        idle();
        mid();
        checks++; if (o_bp_valid !== 1'b1) begin failures++; $display("FAIL single_bp_valid got=%b exp=1", o_bp_valid); end
        checks++; if (o_bp_bid !== 4'h0) begin failures++; $display("FAIL single_bp_bid got=%h exp=0", o_bp_bid); end
        checks++; if (o_bp_rob !== 5'h0A) begin failures++; $display("FAIL single_bp_rob got=%h exp=0a", o_bp_rob); end
        checks++; if (o_bp_target !== 32'h0000_1000) begin failures++; $display("FAIL single_bp_target got=%h exp=00001000", o_bp_target); end
        checks++; if (o_empty !== 1'b0) begin failures++; $display("FAIL single_empty got=%b exp=0", o_empty); end
        nxt();
        mid();
        checks++; if (o_bp_valid !== 1'b0) begin failures++; $display("FAIL single_bp_drop got=%b exp=0", o_bp_valid); end
        nxt();
        i_bc_valid = 1'b1; i_bc_bid = 4'h0;
        nxt();
        idle();
        mid();
        checks++; if (o_empty !== 1'b1) begin failures++; $display("FAIL single_drain got=%b exp=1", o_empty); end
        nxt();
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            req(32'h2000 + 32'(i * 4), 5'(i + 16));
            mid();
            checks++; if (o_br_ready !== 1'b1) begin failures++; $display("FAIL full_ready_%0d got=%b exp=1", i, o_br_ready); end
            if (i > 0) begin
                checks++; if (o_bp_bid !== 4'(i - 1)) begin failures++; $display("FAIL full_bid_%0d got=%h exp=%h", i, o_bp_bid, 4'(i - 1)); end
            end
            nxt();
        end
        req(32'h3000, 5'h1F);
        mid();
        checks++; if (o_br_ready !== 1'b0) begin failures++; $display("FAIL full_ninth got=%b exp=0", o_br_ready); end
        checks++; if (o_bp_bid !== 4'h7) begin failures++; $display("FAIL full_bid_7 got=%h exp=7", o_bp_bid); end
        nxt();
        i_bc_valid = 1'b1; i_bc_bid = 4'h0;
        mid();
        checks++; if (o_br_ready !== 1'b0) begin failures++; $display("FAIL full_nobypass got=%b exp=0", o_br_ready); end
        nxt();
        i_bc_valid = 1'b0;
        mid();
        checks++; if (o_br_ready !== 1'b1) begin failures++; $display("FAIL full_freed got=%b exp=1", o_br_ready); end
        nxt();
        idle();
        mid();
        checks++; if (o_bp_bid !== 4'h8) begin failures++; $display("FAIL full_bid_8 got=%h exp=8", o_bp_bid); end
        nxt();
        for (int b = 1; b <= 8; b++) begin
            i_bc_valid = 1'b1; i_bc_bid = 4'(b);
            nxt();
        end
        idle();
        mid();
        checks++; if (o_empty !== 1'b1) begin failures++; $display("FAIL full_drain got=%b exp=1", o_empty); end
        nxt();
    endtask

    // Head and tail sit at 9 on entry, so 20 pairs cross the 15 -> 0 wrap.
    task automatic test_wrap();
        bid_t b = 4'h9;
        int   low_ready = 0;
        for (int i = 0; i < 20; i++) begin
            req(32'h4000 + 32'(i * 8), 5'(i));
            mid();
            if (o_br_ready !== 1'b1) low_ready++;
            nxt();
            idle();
            i_bc_valid = 1'b1; i_bc_bid = b;
            mid();
            checks++; if (o_bp_bid !== b) begin failures++; $display("FAIL wrap_bid_%0d got=%h exp=%h", i, o_bp_bid, b); end
            checks++; if (o_empty !== 1'b0) begin failures++; $display("FAIL wrap_busy_%0d got=%b exp=0", i, o_empty); end
            nxt();
            idle();
            b = b + bid_t'(1);
        end
        mid();
        checks++; if (low_ready !== 0) begin failures++; $display("FAIL wrap_ready_low got=%0d exp=0", low_ready); end
        checks++; if (o_empty !== 1'b1) begin failures++; $display("FAIL wrap_empty got=%b exp=1", o_empty); end
        checks++; if (o_err !== 1'b0) begin failures++; $display("FAIL wrap_err got=%b exp=0", o_err); end
        nxt();
    endtask

    task automatic test_override();
        do_reset();
        for (int i = 0; i < 7; i++) begin
            req(32'h5000 + 32'(i), 5'(i));
            nxt();
        end
        idle();
        for (int i = 0; i < 3; i++) begin
            i_bc_valid = 1'b1; i_bc_bid = 4'(i);
            nxt();
        end
        req(32'h6000, 5'h06);
        i_bc_valid = 1'b1; i_bc_bid = 4'h3;
        i_bco_valid = 1'b1; i_bco_bid = 4'h3;
        mid();
        checks++; if (o_br_ready !== 1'b0) begin failures++; $display("FAIL ovr_concurrent got=%b exp=0", o_br_ready); end
        nxt();
        i_bc_valid = 1'b0; i_bco_valid = 1'b0;
        mid();
        checks++; if (o_empty !== 1'b1) begin failures++; $display("FAIL ovr_empty got=%b exp=1", o_empty); end
        checks++; if (o_br_ready !== 1'b0) begin failures++; $display("FAIL ovr_hold1 got=%b exp=0", o_br_ready); end
        nxt();
        mid();
        checks++; if (o_br_ready !== 1'b0) begin failures++; $display("FAIL ovr_hold2 got=%b exp=0", o_br_ready); end
        nxt();
        mid();
        checks++; if (o_br_ready !== 1'b1) begin failures++; $display("FAIL ovr_resume got=%b exp=1", o_br_ready); end
        nxt();
        idle();
        mid();
        checks++; if (o_bp_bid !== 4'h4) begin failures++; $display("FAIL ovr_next_bid got=%h exp=4", o_bp_bid); end
        nxt();
        i_bc_valid = 1'b1; i_bc_bid = 4'h4;
        nxt();
        idle();
        mid();
        checks++; if (o_err !== 1'b0) begin failures++; $display("FAIL ovr_err got=%b exp=0", o_err); end
        nxt();
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 7; i++) begin
            req(32'h7000 + 32'(i), 5'(i));
            nxt();
        end
        req(32'h7100, 5'h07);
        i_bc_valid = 1'b1; i_bc_bid = 4'h0;
        mid();
        checks++; if (o_br_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready got=%b exp=1", o_br_ready); end
        nxt();
        i_bc_valid = 1'b0;
        req(32'h7200, 5'h08);
        mid();
        checks++; if (o_br_ready !== 1'b1) begin failures++; $display("FAIL b2b_count7 got=%b exp=1", o_br_ready); end
        nxt();
        idle();
        mid();
        checks++; if (o_br_ready !== 1'b0) begin failures++; $display("FAIL b2b_full got=%b exp=0", o_br_ready); end
        nxt();
    endtask

    task automatic test_err();
        do_reset();
        req(32'h8000, 5'h01);
        nxt();
        req(32'h8004, 5'h02);
        nxt();
        idle();
        i_bc_valid = 1'b1; i_bc_bid = 4'h0;
        nxt();
        i_bc_bid = 4'h2;
        mid();
        checks++; if (o_err !== 1'b0) begin failures++; $display("FAIL err_before got=%b exp=0", o_err); end
        nxt();
        idle();
        mid();
        checks++; if (o_err !== EXP_ERR) begin failures++; $display("FAIL err_set got=%b exp=%b", o_err, EXP_ERR); end
        for (int i = 0; i < 3; i++) nxt();
        mid();
        checks++; if (o_err !== EXP_ERR) begin failures++; $display("FAIL err_sticky got=%b exp=%b", o_err, EXP_ERR); end
        nxt();
        do_reset();
        mid();
        checks++; if (o_err !== 1'b0) begin failures++; $display("FAIL err_cleared got=%b exp=0", o_err); end
        nxt();
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            req(32'h9000 + 32'(i), 5'(i));
            nxt();
        end
        req(32'h9100, 5'h0C);
        resetn = 1'b0;
        nxt();
        resetn = 1'b1;
        idle();
        mid();
        checks++; if (o_bp_valid !== 1'b0) begin failures++; $display("FAIL rmid_bp_valid got=%b exp=0", o_bp_valid); end
        checks++; if (o_empty !== 1'b1) begin failures++; $display("FAIL rmid_empty got=%b exp=1", o_empty); end
        checks++; if (o_br_ready !== 1'b1) begin failures++; $display("FAIL rmid_ready got=%b exp=1", o_br_ready); end
        nxt();
    endtask

    initial begin
        resetn = 1'b0;
        idle();
        test_reset();
        test_single();
        test_full();
        test_wrap();
        test_override();
        test_back_to_back();
        test_err();
        test_reset_mid();
        nxt();
        nxt();
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL sb_leftover got=%0d exp=0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/decode_bta.md
DECODE_BTA -- requirements
Module: decode_bta

Interface
REQ-001 Parameter: RECOVER_CYCLES, 2, allocation-blocked cycles after an override (legal 1..7).
REQ-002 clk  in  1  clock; all logic on posedge.
REQ-003 resetn  in  1  reset, synchronous, active-low.
REQ-004 i_br_valid  in  1  decoded branch requests a branch ID.
REQ-005 i_br_taken / i_br_hit  in  1 each  prediction direction / BTB hit.
REQ-006 i_br_target  in  32  predicted target.
REQ-007 i_br_rob  in  5  ROB address allocated to the branch.
REQ-008 o_br_ready  out  1  request accepted this cycle when high with i_br_valid.
REQ-009 o_bp_valid, o_bp_bid[3:0], o_bp_taken, o_bp_hit, o_bp_target[31:0], o_bp_rob[4:0]  out  prediction record towards the branch record table.
REQ-010 i_bc_valid, i_bc_bid[3:0]  in  branch commit from the branch record table.
REQ-011 i_bco_valid, i_bco_bid[3:0]  in  branch commit override (mispredict) from the branch record table.
REQ-012 o_empty  out  1  no branch IDs in flight.
REQ-013 o_err  out  1  sticky protocol error (see Configuration).

Function
REQ-014 Block SHALL keep 4-bit alloc pointer (tail) and commit pointer (head); bid = pointer value, bid[2:0] = table index, bid[3] = wrap bit.
REQ-015 count = (tail - head) mod 16; full when count == 8, empty when count == 0.
REQ-016 State machine: RUN, HOLD; reset -> RUN; RUN -> HOLD on i_bco_valid; HOLD -> RUN after RECOVER_CYCLES cycles counted by a 3-bit down-counter loaded on entry.
REQ-017 o_br_ready = (state == RUN) & ~full & ~i_bco_valid, computed from registered count; no same-cycle bypass of a freeing commit.
REQ-018 On accept (i_br_valid & o_br_ready): bid = tail; tail increments mod 16.
REQ-019 o_bp_* SHALL be registered, valid exactly 1 cycle after accept, o_bp_bid = allocated bid, other fields copied from i_br_*; o_bp_valid low otherwise.
REQ-020 On i_bc_valid without override: head increments mod 16; commits are in order.
REQ-021 On i_bco_valid (always accompanied by i_bc_valid, same bid): head and tail both set to i_bco_bid + 1 mod 16 (all younger IDs discarded, structure empty); concurrent request not accepted.
REQ-022 Accept and commit in same cycle: both applied; count unchanged.
REQ-023 Pointer wrap 15 -> 0 SHALL be seamless; full/empty decisions remain correct across wrap.
REQ-024 i_bc_valid while HOLD SHALL still advance head.

Reset
REQ-025 resetn low: head = tail = 0, state = RUN, counter = 0, o_bp_valid = 0, all o_bp_* fields = 0, o_err = 0; o_empty = 1, o_br_ready = 1 in the first cycle after reset.
REQ-026 Reset mid-operation discards all in-flight IDs and any pending o_bp_valid.

Configuration
REQ-027 Macro DECODE_BTA_ERRCHK_EN defined: o_err set and held until reset when i_bc_valid arrives while empty or i_bc_bid != head.
REQ-028 Macro undefined: checking logic omitted, o_err tied 0, pointer behaviour unchanged.

Structure
REQ-029 Shared package decode_pkg holds BID_W = 4, BRT_DEPTH = 8, ROB_ADDR_W = 5 and the RUN/HOLD state encoding.
REQ-030 Single module, no sub-module; pointer/count logic inline.

Verification
REQ-031 Reset, request with i_br_rob=5'h0A, target 32'h0000_1000 -> next cycle o_bp_valid=1, o_bp_bid=0, o_bp_rob=5'h0A, o_bp_target=32'h0000_1000.
REQ-032 8 back-to-back requests, no commits -> bids 0..7, o_br_ready=0 on 9th cycle; one commit bid 0 -> o_br_ready=1 next cycle, next bid = 8.
REQ-033 Run 20 allocate/commit pairs -> bids wrap 15 -> 0, o_empty, o_br_ready never wrongly low, o_err=0.
REQ-034 Allocate bids 3..6, i_bc/i_bco bid=3 -> o_empty=1, o_br_ready=0 for 2 cycles (RECOVER_CYCLES=2), next accepted bid = 4.
REQ-035 With DECODE_BTA_ERRCHK_EN: commit bid 2 when head=1 -> o_err=1 next cycle, stays 1 until resetn low; without macro -> o_err=0.
REQ-036 Simultaneous accept and commit at count=8-1 -> count stays 7, ready stays 1.
